// File: rtl/coin_pkg.sv
// Shared types, coin values and lookup helpers for the coin decoder.
// Imported by the sampler and the credit datapath.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_code_t;

  localparam logic [4:0] NICKEL_VALUE  = 5'd5;
  localparam logic [4:0] DIME_VALUE    = 5'd10;
  localparam logic [4:0] QUARTER_VALUE = 5'd25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FILTER = 2'd2
  } sampler_state_t;

  function automatic logic [4:0] coin_value(input coin_code_t code);
    logic [4:0] value;
    value = 5'd0;
    case (code)
      COIN_NICKEL:  value = NICKEL_VALUE;
      COIN_DIME:    value = DIME_VALUE;
      COIN_QUARTER: value = QUARTER_VALUE;
      default:      value = 5'd0;
    endcase
    return value;
  endfunction

  function automatic logic [2:0] coin_onehot(input coin_code_t code);
    logic [2:0] onehot;
    onehot = 3'b000;
    case (code)
      COIN_NICKEL:  onehot = 3'b001;
      COIN_DIME:    onehot = 3'b010;
      COIN_QUARTER: onehot = 3'b100;
      default:      onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/coin_decoder_if.sv
// Coin path and vending-FSM request/response bundle for the coin decoder.
// master = sensor/vending side, slave = coin_decoder.
interface coin_decoder_if #(
  parameter int CREDIT_W = 8
);

  logic [1:0]          code_i;
  logic                clear_i;
  logic                spend_i;
  logic [CREDIT_W-1:0] spend_amt_i;
  logic [2:0]          coin_o;
  logic                reject_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                spend_ack_o;
  logic                spend_nack_o;

  modport master (
    output code_i, clear_i, spend_i, spend_amt_i,
    input  coin_o, reject_o, credit_o, spend_ack_o, spend_nack_o
  );

  modport slave (
    input  code_i, clear_i, spend_i, spend_amt_i,
    output coin_o, reject_o, credit_o, spend_ack_o, spend_nack_o
  );

endinterface

// File: rtl/coin_code_sampler.sv
// Registers the sensor code and runs the one-coin-per-insertion FSM.
// Optional glitch filter: define COIN_DEC_GLITCH_FILTER_EN.
module coin_code_sampler
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  output logic       accept,
  output coin_code_t coin
);

  coin_code_t     code_q;
  sampler_state_t state;
  logic           code_valid;
`ifdef COIN_DEC_GLITCH_FILTER_EN
  coin_code_t     captured;
`endif

  // code_valid masks the reset value of code_q, so a code held through reset
  // release keeps the FSM in HOLD until a real 00 has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= COIN_NONE;
      code_valid <= 1'b0;
      state      <= HOLD;
`ifdef COIN_DEC_GLITCH_FILTER_EN
      captured   <= COIN_NONE;
`endif
    end else begin
      code_q     <= coin_code_t'(code);
      code_valid <= 1'b1;
      case (state)
        IDLE: begin
          if (code_q != COIN_NONE) begin
`ifdef COIN_DEC_GLITCH_FILTER_EN
            state    <= FILTER;
            captured <= code_q;
`else
            state    <= HOLD;
`endif
          end
        end
        HOLD: begin
          if (code_valid && code_q == COIN_NONE) state <= IDLE;
        end
`ifdef COIN_DEC_GLITCH_FILTER_EN
        FILTER: begin
          if (code_q == COIN_NONE) state <= IDLE;
          else                     state <= HOLD;
        end
`endif
        default: state <= HOLD;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    coin   = code_q;
`ifdef COIN_DEC_GLITCH_FILTER_EN
    if (state == FILTER && code_q == captured) accept = 1'b1;
`else
    if (state == IDLE && code_q != COIN_NONE) accept = 1'b1;
`endif
  end

endmodule

// File: rtl/coin_decoder.sv
// Coin decoder top: sampler plus saturating credit register with clear/spend.
// Glitch filter in the sampler is enabled by COIN_DEC_GLITCH_FILTER_EN.
module coin_decoder
  import coin_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200
) (
  input logic           clk,
  input logic           rst_n,
  coin_decoder_if.slave bus
);

  localparam logic [CREDIT_W:0] CEILING = (CREDIT_W+1)'(MAX_CREDIT);

  logic                accept;
  coin_code_t          coin;
  logic [CREDIT_W-1:0] credit;
  logic [2:0]          coin_q;
  logic                reject_q;
  logic                ack_q;
  logic                nack_q;
  logic                spend_ok;
  logic [CREDIT_W:0]   base;
  logic [CREDIT_W:0]   sum;
  logic                coin_fits;

  coin_code_sampler u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .code   (bus.code_i),
    .accept (accept),
    .coin   (coin)
  );

  // Clear/spend settle first; the coin is then judged against what remains.
  // One extra bit keeps the sum from wrapping before the ceiling compare.
  always_comb begin
    spend_ok = (bus.spend_amt_i <= credit);
    base     = {1'b0, credit};
    if (bus.clear_i)                 base = '0;
    else if (bus.spend_i && spend_ok) base = {1'b0, credit - bus.spend_amt_i};
    sum       = base + (CREDIT_W+1)'(coin_value(coin));
    coin_fits = (sum <= CEILING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit   <= '0;
      coin_q   <= 3'b000;
      reject_q <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      coin_q   <= 3'b000;
      reject_q <= 1'b0;
      ack_q    <= bus.spend_i && !bus.clear_i && spend_ok;
      nack_q   <= bus.spend_i && !bus.clear_i && !spend_ok;
      credit   <= base[CREDIT_W-1:0];
      if (accept) begin
        if (coin_fits) begin
          credit <= sum[CREDIT_W-1:0];
          coin_q <= coin_onehot(coin);
        end else begin
          reject_q <= 1'b1;
        end
      end
    end
  end

  assign bus.coin_o       = coin_q;
  assign bus.reject_o     = reject_q;
  assign bus.credit_o     = credit;
  assign bus.spend_ack_o  = ack_q;
  assign bus.spend_nack_o = nack_q;

endmodule

// File: tb/tb_coin_decoder.sv
// Self-checking bench for coin_decoder: directed scenarios plus random coin/spend
// traffic, all checked against an episode-level credit model.
module tb_coin_decoder;

`ifdef COIN_DEC_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int MAXC = 200;

  logic clk;
  logic rst_n;
  int   test_count;
  int   fail_count;

  coin_decoder_if #(.CREDIT_W(8)) bus ();

  coin_decoder #(.CREDIT_W(8), .MAX_CREDIT(MAXC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: credit in cents, last sampled code, and at most one coin
  // waiting to be judged at edge pend_due.
  int         m_credit;
  logic [2:0] m_coin;
  bit         m_reject, m_ack, m_nack;
  int         m_prev_code;
  int         edge_num;
  int         pend_due;
  int         pend_code;

  function automatic int value_of(input int code);
    if (code == 1) return 5;
    if (code == 2) return 10;
    if (code == 3) return 25;
    return 0;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".coin"},   int'(bus.coin_o),       int'(m_coin));
    check({tag, ".reject"}, int'(bus.reject_o),     int'(m_reject));
    check({tag, ".credit"}, int'(bus.credit_o),     m_credit);
    check({tag, ".ack"},    int'(bus.spend_ack_o),  int'(m_ack));
    check({tag, ".nack"},   int'(bus.spend_nack_o), int'(m_nack));
  endtask

  task automatic modelEdge(input int code, input bit clr, input bit spd, input int amt);
    int v;
    int base;
    v = 0;
    if (pend_due == edge_num) begin
      v = value_of(pend_code);
      pend_due = -1;
    end
`ifdef COIN_DEC_GLITCH_FILTER_EN
    else if (pend_due == edge_num + 1 && code != pend_code) begin
      pend_due = -1;
    end
`endif
    if (code != 0 && m_prev_code == 0 && pend_due < 0) begin
      pend_due  = edge_num + LAT;
      pend_code = code;
    end
    m_prev_code = code;
    m_ack  = spd && !clr && amt <= m_credit;
    m_nack = spd && !clr && amt > m_credit;
    if (clr)        base = 0;
    else if (m_ack) base = m_credit - amt;
    else            base = m_credit;
    m_coin   = 3'b000;
    m_reject = 1'b0;
    m_credit = base;
    if (v != 0) begin
      if (base + v <= MAXC) begin
        m_credit = base + v;
        m_coin   = (v == 5) ? 3'b001 : (v == 10) ? 3'b010 : 3'b100;
      end else begin
        m_reject = 1'b1;
      end
    end
    edge_num++;
  endtask

  task automatic applyStimulus(input int code, input bit clr, input bit spd, input int amt,
                               input string tag);
    @(negedge clk);
    bus.code_i      = 2'(code);
    bus.clear_i     = clr;
    bus.spend_i     = spd;
    bus.spend_amt_i = 8'(amt);
    @(posedge clk);
    modelEdge(code, clr, spd, amt);
    #1;
    checkOutput(tag);
  endtask

  task automatic insertCoin(input int code, input int hold, input string tag);
    repeat (hold) applyStimulus(code, 1'b0, 1'b0, 0, tag);
    applyStimulus(0, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic doReset(input int code, input string tag);
    @(negedge clk);
    rst_n           = 1'b0;
    bus.code_i      = 2'(code);
    bus.clear_i     = 1'b0;
    bus.spend_i     = 1'b0;
    bus.spend_amt_i = 8'd0;
    #1;
    m_credit    = 0;
    m_coin      = 3'b000;
    m_reject    = 1'b0;
    m_ack       = 1'b0;
    m_nack      = 1'b0;
    m_prev_code = 3;
    pend_due    = -1;
    checkOutput({tag, ".in_reset"});
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, ".held_reset"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    edge_num   = 0;
    rst_n      = 1'b0;

    // Single quarter held for several cycles counts once
    doReset(0, "q_reset");
    repeat (2) applyStimulus(0, 0, 0, 0, "q_idle");
    repeat (4) applyStimulus(3, 0, 0, 0, "q_hold");
    repeat (2) applyStimulus(0, 0, 0, 0, "q_done");
    check("q_credit25", int'(bus.credit_o), 25);

    // Dime held through reset release is ignored; the next dime counts
    doReset(2, "d_reset");
    repeat (3) applyStimulus(2, 0, 0, 0, "d_held");
    applyStimulus(0, 0, 0, 0, "d_gap");
    repeat (3) applyStimulus(2, 0, 0, 0, "d_second");
    repeat (2) applyStimulus(0, 0, 0, 0, "d_done");
    check("d_credit10", int'(bus.credit_o), 10);

    // Ceiling: reach 190, reject a quarter, land exactly on 200, reject a nickel
    doReset(0, "c_reset");
    applyStimulus(0, 0, 0, 0, "c_idle");
    repeat (7) insertCoin(3, 2, "c_fill");
    insertCoin(2, 2, "c_fill");
    insertCoin(1, 2, "c_fill");
    check("c_credit190", int'(bus.credit_o), 190);
    insertCoin(3, 2, "c_reject_q");
    check("c_still190", int'(bus.credit_o), 190);
    insertCoin(2, 2, "c_exact200");
    check("c_credit200", int'(bus.credit_o), 200);
    insertCoin(1, 2, "c_reject_n");
    check("c_stay200", int'(bus.credit_o), 200);

    // Spend refused, then spend granted in the cycle a quarter lands
    applyStimulus(0, 1, 0, 0, "s_clear");
    insertCoin(3, 2, "s_fill");
    insertCoin(1, 2, "s_fill");
    applyStimulus(0, 0, 1, 35, "s_nack");
    applyStimulus(3, 0, 0, 0, "s_q_start");
    repeat (LAT - 1) applyStimulus(3, 0, 0, 0, "s_q_wait");
    applyStimulus(3, 0, 1, 30, "s_ack_with_coin");
    applyStimulus(0, 0, 0, 0, "s_done");
    check("s_credit25", int'(bus.credit_o), 25);

    // Clear beats spend and the coin still lands on the cleared credit
    insertCoin(3, 2, "k_fill");
    check("k_credit50", int'(bus.credit_o), 50);
    applyStimulus(1, 0, 0, 0, "k_n_start");
    repeat (LAT - 1) applyStimulus(1, 0, 0, 0, "k_n_wait");
    applyStimulus(1, 1, 1, 10, "k_clear_spend");
    applyStimulus(0, 0, 0, 0, "k_done");
    check("k_credit5", int'(bus.credit_o), 5);

    // Changed code while held belongs to the same insertion
    insertCoin(0, 1, "v_gap");
    applyStimulus(3, 0, 0, 0, "v_q");
    applyStimulus(1, 0, 0, 0, "v_n");
    applyStimulus(1, 0, 0, 0, "v_n");
    insertCoin(0, 1, "v_done");

    // Reset mid-coin clears everything; held code stays ignored after release
    insertCoin(2, 3, "m_fill");
    applyStimulus(3, 0, 0, 0, "m_q");
    applyStimulus(3, 0, 0, 0, "m_q");
    doReset(3, "m_reset");
    repeat (2) applyStimulus(3, 0, 0, 0, "m_after");
    applyStimulus(0, 0, 0, 0, "m_gap");
    insertCoin(1, 2, "m_nickel");
    check("m_credit5", int'(bus.credit_o), 5);

`ifdef COIN_DEC_GLITCH_FILTER_EN
    // One-cycle blip is filtered; a stable nickel counts
    applyStimulus(1, 0, 0, 0, "f_blip");
    applyStimulus(0, 0, 0, 0, "f_blip_end");
    applyStimulus(0, 0, 0, 0, "f_blip_end");
    check("f_no_pulse", int'(bus.credit_o), 5);
    repeat (3) applyStimulus(1, 0, 0, 0, "f_stable");
    applyStimulus(0, 0, 0, 0, "f_done");
    check("f_credit10", int'(bus.credit_o), 10);
`endif

    // Random coin episodes with interleaved clear/spend requests
    for (int ep = 0; ep < 60; ep++) begin
      int code;
      int gap;
      int hold;
      gap  = $urandom_range(1, 3);
      hold = $urandom_range(2, 4);
      code = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++)
        applyStimulus(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 60), "r_gap");
      for (int h = 0; h < hold; h++)
        applyStimulus(code, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 60), "r_coin");
    end
    applyStimulus(0, 0, 0, 0, "r_done");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
